iopmp_cfg_regs: RTL

Parametrised configuration register file for the IOPMP checker. It replaces the fixed 2-MD/8-entry register block.
- Generalised in entry count, memory-domain count and address width.
- Adds per-entry lock with TOR lock propagation, a sticky global MDLCK lock, WARL field legalisation, and a registered response channel with decode error.
- Sits between the config bus bridge and the match/arbitration logic. Drives that logic with flattened entry and MD state.

---
 rtl/iopmp_cfg_regs.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/iopmp_cfg_regs.sv
// IOPMP configuration register file: entry address/config, MD top indices and MDLCK,
// with WARL legalisation, entry/TOR locking and a one-cycle registered response.
module iopmp_cfg_regs #(
  parameter int                    NR_ENTRIES = 16,
  parameter int                    NR_MD      = 4,
  parameter int                    IOPMP_LEN  = 54,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h5000_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [63:0]                     wdata_i,
  output logic                            rvalid_o,
  output logic [63:0]                     rdata_o,
  output logic                            err_o,
  output logic [NR_ENTRIES*IOPMP_LEN-1:0] entry_addr_o,
  output logic [NR_ENTRIES*8-1:0]         entry_cfg_o,
  output logic [NR_MD*16-1:0]             mdcfg_o,
  output logic [NR_MD:0]                  mdlck_o
);

  logic [ADDR_WIDTH-1:0] off;
  logic                  sel_mdlck, in_mdcfg, in_eaddr, in_ecfg;
  logic [4:0]            md_idx;
  logic [5:0]            ea_idx, ec_idx;

  logic [IOPMP_LEN-1:0] addr_q  [NR_ENTRIES];
  logic [IOPMP_LEN-1:0] addr_d  [NR_ENTRIES];
  logic [7:0]           cfg_q   [NR_ENTRIES];
  logic [7:0]           cfg_d   [NR_ENTRIES];
  logic [15:0]          mdcfg_q [NR_MD];
  logic [15:0]          mdcfg_d [NR_MD];
  logic [15:0]          md_floor[NR_MD];
  logic                 lck_l_q, lck_l_d;
  logic [NR_MD-1:0]     md_lck_q, md_lck_d;
  logic [NR_ENTRIES-1:0] addr_lock;
  logic [15:0]          t_sat;
  logic [7:0]           cfg_legal;
  logic                 hit;
  logic [63:0]          rd_val;
  logic                 unused_wdata;

  // Windows are checked for range and natural alignment; out-of-range indices simply
  // fail to match any register below and fall through to a decode error.
  assign off       = addr_i - BASE_ADDR;
  assign sel_mdlck = (off == '0);
  assign in_mdcfg  = (off >= ADDR_WIDTH'(14'h0800)) && (off < ADDR_WIDTH'(14'h0880)) &&
                     (off[1:0] == 2'b00);
  assign in_eaddr  = (off >= ADDR_WIDTH'(14'h2000)) && (off < ADDR_WIDTH'(14'h2200)) &&
                     (off[2:0] == 3'b000);
  assign in_ecfg   = (off >= ADDR_WIDTH'(14'h3000)) && (off < ADDR_WIDTH'(14'h3040));
  assign md_idx    = off[6:2];
  assign ea_idx    = off[8:3];
  assign ec_idx    = off[5:0];

  assign t_sat     = (wdata_i[15:0] > 16'(NR_ENTRIES)) ? 16'(NR_ENTRIES) : wdata_i[15:0];
  assign cfg_legal = {wdata_i[7], 2'b00, wdata_i[4:2], wdata_i[1] & wdata_i[0], wdata_i[0]};
  assign unused_wdata = ^wdata_i;

  // An address is frozen by its own L bit or by a locked TOR successor.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) addr_lock[i] = cfg_q[i][7];
    for (int i = 0; i < NR_ENTRIES - 1; i++)
      if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01)) addr_lock[i] = 1'b1;
  end

  always_comb begin
    md_floor[0] = '0;
    for (int m = 1; m < NR_MD; m++) md_floor[m] = mdcfg_q[m-1];
  end

  always_comb begin
    addr_d   = addr_q;
    cfg_d    = cfg_q;
    mdcfg_d  = mdcfg_q;
    lck_l_d  = lck_l_q;
    md_lck_d = md_lck_q;
    hit      = 1'b0;
    rd_val   = '0;
    if (req_i) begin
      if (sel_mdlck) begin
        hit = 1'b1;
        if (we_i && !lck_l_q) begin
          lck_l_d  = wdata_i[0];
          md_lck_d = md_lck_q | wdata_i[NR_MD:1];
        end
        rd_val = 64'({md_lck_d, lck_l_d});
      end
      for (int m = 0; m < NR_MD; m++) begin
        if (in_mdcfg && (md_idx == 5'(m))) begin
          hit = 1'b1;
          if (we_i && !lck_l_q && !md_lck_q[m])
            mdcfg_d[m] = (t_sat < md_floor[m]) ? md_floor[m] : t_sat;
          rd_val = 64'(mdcfg_d[m]);
        end
      end
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (in_eaddr && (ea_idx == 6'(i))) begin
          hit = 1'b1;
          if (we_i && !addr_lock[i]) addr_d[i] = wdata_i[IOPMP_LEN-1:0];
          rd_val = 64'(addr_d[i]);
        end
        if (in_ecfg && (ec_idx == 6'(i))) begin
          hit = 1'b1;
          if (we_i && !cfg_q[i][7]) cfg_d[i] = cfg_legal;
          rd_val = 64'(cfg_d[i]);
        end
      end
    end
  end

  // Response channel: every request accepted; rvalid_o pulses on the cycle after req_i,
  // with rdata_o/err_o valid only while rvalid_o is high (no backpressure).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '{default: '0};
      cfg_q    <= '{default: '0};
      mdcfg_q  <= '{default: '0};
      lck_l_q  <= 1'b0;
      md_lck_q <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      cfg_q    <= cfg_d;
      mdcfg_q  <= mdcfg_d;
      lck_l_q  <= lck_l_d;
      md_lck_q <= md_lck_d;
      rvalid_o <= req_i;
      rdata_o  <= rd_val;
      err_o    <= req_i & ~hit;
    end
  end

  always_comb begin
    entry_addr_o = '0;
    entry_cfg_o  = '0;
    mdcfg_o      = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      entry_addr_o[i*IOPMP_LEN +: IOPMP_LEN] = addr_q[i];
      entry_cfg_o[i*8 +: 8]                  = cfg_q[i];
    end
    for (int m = 0; m < NR_MD; m++) mdcfg_o[m*16 +: 16] = mdcfg_q[m];
  end

  assign mdlck_o = {md_lck_q, lck_l_q};

endmodule
